// File: rtl/bcd_countdown_7.sv
// bcd_countdown_7 - two-digit BCD down-counter.
//
// While run is low the counter tracks a binary start value, clamped to 99 and
// shown as two BCD digits. While run is high it decrements once every
// TICK_DIV clocks down to 00, then holds and raises done. The digit format
// matches the two-digit BCD up-counter, so both can share display logic.
//
// Ports:
//   CLK          rising-edge clock
//   RESET        synchronous active-high reset, highest priority
//   run          0 = load/track start value, 1 = count down
//   start_count  binary start value (sampled only in LOAD and on exit paths)
//   digit_1      BCD ones digit (registered)
//   digit_2      BCD tens digit (registered)
//   busy         high while counting (registered)
//   done         high once the count has reached 00 (registered)
//
// state | meaning
// ------+-------------------------------------------------------------
// LOAD  | digits track converted start_count; run=1 enters COUNT
// COUNT | decrement once per prescaler tick; run=0 aborts to LOAD
// DONE  | digits held at 00; run=0 returns to LOAD

module bcd_countdown_7 #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       run,
    input  logic [6:0] start_count,
    output logic [3:0] digit_1,
    output logic [3:0] digit_2,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [15:0] PRESC_LAST = 16'(TICK_DIV - 1);

    state_t      state, state_nxt;
    logic [15:0] presc, presc_nxt;
    logic [3:0]  ones_nxt, tens_nxt;
    logic        busy_nxt, done_nxt;

    logic [6:0]  clamped;
    logic [3:0]  load_ones, load_tens;
    logic        tick;
    logic        at_floor;

    // Clamp to 99 before converting so inputs 100..127 load as 9,9.
    always_comb begin
        clamped   = (start_count > 7'd99) ? 7'd99 : start_count;
        load_tens = 4'(clamped / 7'd10);
        load_ones = 4'(clamped % 7'd10);
    end

    assign tick     = (presc == PRESC_LAST);
    // Values 01 and 00 both finish on the next tick.
    assign at_floor = (digit_2 == 4'd0) && (digit_1 <= 4'd1);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= LOAD;
            presc   <= 16'd0;
            digit_1 <= 4'd0;
            digit_2 <= 4'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            presc   <= presc_nxt;
            digit_1 <= ones_nxt;
            digit_2 <= tens_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LOAD:    if (run) state_nxt = COUNT;
            COUNT: begin
                if (!run)
                    state_nxt = LOAD;
                else if (tick && at_floor)
                    state_nxt = DONE;
            end
            DONE:    if (!run) state_nxt = LOAD;
            default: state_nxt = LOAD;
        endcase
    end

    // Datapath and registered flags, derived from the current state and the
    // state being entered so busy/done change on the same edge as the state.
    always_comb begin
        ones_nxt  = digit_1;
        tens_nxt  = digit_2;
        presc_nxt = 16'd0;
        busy_nxt  = (state_nxt == COUNT);
        done_nxt  = (state_nxt == DONE);
        case (state)
            LOAD: begin
                ones_nxt = load_ones;
                tens_nxt = load_tens;
            end
            COUNT: begin
                if (!run) begin
                    // Abort wins over a coincident tick.
                    ones_nxt = load_ones;
                    tens_nxt = load_tens;
                end else if (tick) begin
                    if (at_floor) begin
                        ones_nxt = 4'd0;
                        tens_nxt = 4'd0;
                    end else if (digit_1 != 4'd0) begin
                        ones_nxt = digit_1 - 4'd1;
                    end else begin
                        ones_nxt = 4'd9;
                        tens_nxt = digit_2 - 4'd1;
                    end
                end else begin
                    presc_nxt = presc + 16'd1;
                end
            end
            DONE: begin
                if (!run) begin
                    ones_nxt = load_ones;
                    tens_nxt = load_tens;
                end else begin
                    ones_nxt = 4'd0;
                    tens_nxt = 4'd0;
                end
            end
            default: begin
                ones_nxt = 4'd0;
                tens_nxt = 4'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_bcd_countdown_7.sv
module tb_bcd_countdown_7;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       run;
    logic [6:0] start_count;
    logic [3:0] digit_1, digit_2;
    logic       busy, done;

    logic       run4;
    logic [6:0] start_count4;
    logic [3:0] digit_1_4, digit_2_4;
    logic       busy4, done4;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    bcd_countdown_7 #(.TICK_DIV(1)) dut (
        .CLK(CLK), .RESET(RESET), .run(run), .start_count(start_count),
        .digit_1(digit_1), .digit_2(digit_2), .busy(busy), .done(done)
    );

    bcd_countdown_7 #(.TICK_DIV(4)) dut4 (
        .CLK(CLK), .RESET(RESET), .run(run4), .start_count(start_count4),
        .digit_1(digit_1_4), .digit_2(digit_2_4), .busy(busy4), .done(done4)
    );

    // Packed observation: {tens, ones, busy, done}
    function automatic logic [9:0] pack(input int v, input logic b, input logic d);
        return {4'(v / 10), 4'(v % 10), b, d};
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        logic [9:0] obs;
        RESET = 1'b1; run = 1'b0; start_count = 7'd73;
        run4 = 1'b0; start_count4 = 7'd5;
        step(); step();
        obs = {digit_2, digit_1, busy, done};
        total++;
        if (obs !== 10'd0) begin
            bad++; $display("FAIL reset got=%h exp=%h", obs, 10'd0);
        end
        obs = {digit_2_4, digit_1_4, busy4, done4};
        total++;
        if (obs !== 10'd0) begin
            bad++; $display("FAIL reset_div4 got=%h exp=%h", obs, 10'd0);
        end
        RESET = 1'b0;
        step();
        obs = {digit_2, digit_1, busy, done};
        total++;
        if (obs !== pack(73, 1'b0, 1'b0)) begin
            bad++; $display("FAIL load73 got=%h exp=%h", obs, pack(73, 1'b0, 1'b0));
        end
    endtask

    task automatic test_count_73();
        logic [9:0] obs;
        run = 1'b1;
        step();
        obs = {digit_2, digit_1, busy, done};
        total++;
        if (obs !== pack(73, 1'b1, 1'b0)) begin
            bad++; $display("FAIL enter73 got=%h exp=%h", obs, pack(73, 1'b1, 1'b0));
        end
        for (int v = 72; v >= 0; v--) begin
            if (v == 50) start_count = 7'd15;
            step();
            obs = {digit_2, digit_1, busy, done};
            total++;
            if (obs !== pack(v, v != 0, v == 0)) begin
                bad++; $display("FAIL count73 v=%0d got=%h exp=%h", v, obs, pack(v, v != 0, v == 0));
            end
        end
        for (int i = 0; i < 3; i++) begin
            step();
            obs = {digit_2, digit_1, busy, done};
            total++;
            if (obs !== pack(0, 1'b0, 1'b1)) begin
                bad++; $display("FAIL hold00 i=%0d got=%h exp=%h", i, obs, pack(0, 1'b0, 1'b1));
            end
        end
    endtask

    task automatic test_reload_15();
        logic [9:0] obs;
        run = 1'b0;
        step();
        obs = {digit_2, digit_1, busy, done};
        total++;
        if (obs !== pack(15, 1'b0, 1'b0)) begin
            bad++; $display("FAIL load15 got=%h exp=%h", obs, pack(15, 1'b0, 1'b0));
        end
        run = 1'b1;
        step();
        for (int v = 14; v >= 0; v--) begin
            step();
            obs = {digit_2, digit_1, busy, done};
            total++;
            if (obs !== pack(v, v != 0, v == 0)) begin
                bad++; $display("FAIL count15 v=%0d got=%h exp=%h", v, obs, pack(v, v != 0, v == 0));
            end
        end
    endtask

    task automatic test_clamp();
        logic [9:0] obs;
        run = 1'b0; start_count = 7'd118;
        step();
        obs = {digit_2, digit_1, busy, done};
        total++;
        if (obs !== pack(99, 1'b0, 1'b0)) begin
            bad++; $display("FAIL clamp118 got=%h exp=%h", obs, pack(99, 1'b0, 1'b0));
        end
        run = 1'b1;
        step();
        for (int v = 98; v >= 0; v--) begin
            step();
            obs = {digit_2, digit_1, busy, done};
            total++;
            if (obs !== pack(v, v != 0, v == 0)) begin
                bad++; $display("FAIL count99 v=%0d got=%h exp=%h", v, obs, pack(v, v != 0, v == 0));
            end
        end
    endtask

    task automatic test_abort();
        logic [9:0] obs;
        run = 1'b0; start_count = 7'd40;
        step();
        run = 1'b1;
        step();
        for (int v = 39; v >= 27; v--) step();
        obs = {digit_2, digit_1, busy, done};
        total++;
        if (obs !== pack(27, 1'b1, 1'b0)) begin
            bad++; $display("FAIL at27 got=%h exp=%h", obs, pack(27, 1'b1, 1'b0));
        end
        run = 1'b0;
        step();
        obs = {digit_2, digit_1, busy, done};
        total++;
        if (obs !== pack(40, 1'b0, 1'b0)) begin
            bad++; $display("FAIL abort got=%h exp=%h", obs, pack(40, 1'b0, 1'b0));
        end
        run = 1'b1;
        step();
        obs = {digit_2, digit_1, busy, done};
        total++;
        if (obs !== pack(40, 1'b1, 1'b0)) begin
            bad++; $display("FAIL restart40 got=%h exp=%h", obs, pack(40, 1'b1, 1'b0));
        end
        step();
        obs = {digit_2, digit_1, busy, done};
        total++;
        if (obs !== pack(39, 1'b1, 1'b0)) begin
            bad++; $display("FAIL restart39 got=%h exp=%h", obs, pack(39, 1'b1, 1'b0));
        end
    endtask

    task automatic test_zero();
        logic [9:0] obs;
        run = 1'b0; start_count = 7'd0;
        step();
        run = 1'b1;
        step();
        obs = {digit_2, digit_1, busy, done};
        total++;
        if (obs !== pack(0, 1'b1, 1'b0)) begin
            bad++; $display("FAIL zero_busy got=%h exp=%h", obs, pack(0, 1'b1, 1'b0));
        end
        step();
        obs = {digit_2, digit_1, busy, done};
        total++;
        if (obs !== pack(0, 1'b0, 1'b1)) begin
            bad++; $display("FAIL zero_done got=%h exp=%h", obs, pack(0, 1'b0, 1'b1));
        end
    endtask

    task automatic test_reset_mid_count();
        logic [9:0] obs;
        run = 1'b0; start_count = 7'd40;
        step();
        run = 1'b1;
        step();
        for (int v = 39; v >= 33; v--) step();
        obs = {digit_2, digit_1, busy, done};
        total++;
        if (obs !== pack(33, 1'b1, 1'b0)) begin
            bad++; $display("FAIL at33 got=%h exp=%h", obs, pack(33, 1'b1, 1'b0));
        end
        RESET = 1'b1; start_count = 7'd62;
        step();
        obs = {digit_2, digit_1, busy, done};
        total++;
        if (obs !== 10'd0) begin
            bad++; $display("FAIL midreset got=%h exp=%h", obs, 10'd0);
        end
        RESET = 1'b0;
        step();
        obs = {digit_2, digit_1, busy, done};
        total++;
        if (obs !== pack(62, 1'b1, 1'b0)) begin
            bad++; $display("FAIL postreset62 got=%h exp=%h", obs, pack(62, 1'b1, 1'b0));
        end
        step();
        obs = {digit_2, digit_1, busy, done};
        total++;
        if (obs !== pack(61, 1'b1, 1'b0)) begin
            bad++; $display("FAIL postreset61 got=%h exp=%h", obs, pack(61, 1'b1, 1'b0));
        end
    endtask

    task automatic test_prescaler();
        logic [9:0] obs;
        int         v;
        run4 = 1'b0; start_count4 = 7'd5;
        step();
        obs = {digit_2_4, digit_1_4, busy4, done4};
        total++;
        if (obs !== pack(5, 1'b0, 1'b0)) begin
            bad++; $display("FAIL div4_load got=%h exp=%h", obs, pack(5, 1'b0, 1'b0));
        end
        run4 = 1'b1;
        step();
        obs = {digit_2_4, digit_1_4, busy4, done4};
        total++;
        if (obs !== pack(5, 1'b1, 1'b0)) begin
            bad++; $display("FAIL div4_enter got=%h exp=%h", obs, pack(5, 1'b1, 1'b0));
        end
        for (int e = 1; e <= 22; e++) begin
            step();
            v = (e >= 20) ? 0 : 5 - e / 4;
            obs = {digit_2_4, digit_1_4, busy4, done4};
            total++;
            if (obs !== pack(v, e < 20, e >= 20)) begin
                bad++; $display("FAIL div4 e=%0d got=%h exp=%h", e, obs, pack(v, e < 20, e >= 20));
            end
        end
    endtask

    initial begin
        test_reset();
        test_count_73();
        test_reload_15();
        test_clamp();
        test_abort();
        test_zero();
        test_reset_mid_count();
        test_prescaler();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
